// File: rtl/dig_clock_pkg.sv
// Shared types and constants for the time-of-day counter.
package dig_clock_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR_MAX   = 23;
  localparam int HR12_MAX = 12;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } tod_t;

  // Maps an internal 0..23 hour to {pm, 1..12}.
  function automatic logic [5:0] to_12h(input logic [4:0] hour);
    logic [4:0] h12;
    logic       pm;
    pm = (hour >= 5'(HR12_MAX));
    if (hour == 5'd0)
      h12 = 5'(HR12_MAX);
    else if (hour > 5'(HR12_MAX))
      h12 = hour - 5'(HR12_MAX);
    else
      h12 = hour;
    return {pm, h12};
  endfunction

endpackage

// File: rtl/dig_clock_core_tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PS_W = $clog2(TICK_DIV) + 1;
  localparam logic [PS_W-1:0] TC = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] r_cnt;
  logic            w_tc;

  assign w_tc   = (r_cnt == TC);
  assign o_tick = i_run & w_tc;

  // Free-running count 0..TICK_DIV-1, frozen when not running, cleared by a load.
  always_ff @(posedge i_clk) begin
    if (!i_reset)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_run)
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/dig_clock_core.sv
// Time-of-day counter: prescaled 1 Hz tick, 24 h internal state, 12/24 h display,
// validated time load. Optional alarm enabled with DIG_CLOCK_ALARM_EN.
module dig_clock_core
  import dig_clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic       i_mode,
  input  logic       i_load_valid,
  output logic       o_load_ready,
  input  logic [5:0] i_s_in,
  input  logic [5:0] i_m_in,
  input  logic [4:0] i_h_in,
  input  logic       i_pm_in,
  output logic       o_load_err,
  output logic [5:0] o_seconds,
  output logic [5:0] o_minutes,
  output logic [4:0] o_hours,
  output logic       o_pm,
  output logic       o_sec_tick,
  output logic       o_day_wrap,
  input  logic       i_alarm_wr,
  input  logic [4:0] i_alarm_h,
  input  logic [5:0] i_alarm_m,
  input  logic       i_alarm_arm,
  output logic       o_alarm_hit
);

  tod_t       r_tod;
  logic       r_load_ready;
  logic       r_load_err;
  logic       r_sec_tick;
  logic       r_day_wrap;

  tod_t       w_next;
  tod_t       w_load_tod;
  logic       w_wrap;
  logic       w_tick;
  logic       w_accept;
  logic       w_load_ok;
  logic       w_tick_apply;
  logic [5:0] w_hr12;

  assign w_accept     = i_load_valid & r_load_ready;
  // Any accepted load, good or bad, swallows a coincident tick.
  assign w_tick_apply = w_tick & ~w_accept;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_run   (i_run),
    .i_clr   (w_accept & w_load_ok),
    .o_tick  (w_tick)
  );

  // Next time-of-day with all carries resolved in one step.
  always_comb begin
    w_next = r_tod;
    w_wrap = 1'b0;
    if (r_tod.s == 6'(SEC_MAX)) begin
      w_next.s = '0;
      if (r_tod.m == 6'(MIN_MAX)) begin
        w_next.m = '0;
        if (r_tod.h == 5'(HR_MAX)) begin
          w_next.h = '0;
          w_wrap   = 1'b1;
        end else begin
          w_next.h = r_tod.h + 1'b1;
        end
      end else begin
        w_next.m = r_tod.m + 1'b1;
      end
    end else begin
      w_next.s = r_tod.s + 1'b1;
    end
  end

  // Range check and conversion of the load request into 24 h form.
  always_comb begin
    w_load_tod.s = i_s_in;
    w_load_tod.m = i_m_in;
    w_load_tod.h = i_h_in;
    w_load_ok    = (i_s_in <= 6'(SEC_MAX)) && (i_m_in <= 6'(MIN_MAX));
    if (i_mode) begin
      w_load_ok    = w_load_ok && (i_h_in >= 5'd1) && (i_h_in <= 5'(HR12_MAX));
      w_load_tod.h = ((i_h_in == 5'(HR12_MAX)) ? 5'd0 : i_h_in) +
                     (i_pm_in ? 5'(HR12_MAX) : 5'd0);
    end else begin
      w_load_ok    = w_load_ok && (i_h_in <= 5'(HR_MAX));
    end
  end

  // Time state and status pulses; reset beats load, load beats tick.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_tod        <= '0;
      r_load_ready <= 1'b0;
      r_load_err   <= 1'b0;
      r_sec_tick   <= 1'b0;
      r_day_wrap   <= 1'b0;
    end else begin
      r_load_ready <= 1'b1;
      r_load_err   <= 1'b0;
      r_sec_tick   <= 1'b0;
      r_day_wrap   <= 1'b0;
      if (w_accept) begin
        if (w_load_ok)
          r_tod <= w_load_tod;
        else
          r_load_err <= 1'b1;
      end else if (w_tick) begin
        r_tod      <= w_next;
        r_sec_tick <= 1'b1;
        r_day_wrap <= w_wrap;
      end
    end
  end

  assign w_hr12       = to_12h(r_tod.h);
  assign o_seconds    = r_tod.s;
  assign o_minutes    = r_tod.m;
  assign o_hours      = i_mode ? w_hr12[4:0] : r_tod.h;
  assign o_pm         = i_mode & w_hr12[5];
  assign o_load_ready = r_load_ready;
  assign o_load_err   = r_load_err;
  assign o_sec_tick   = r_sec_tick;
  assign o_day_wrap   = r_day_wrap;

`ifdef DIG_CLOCK_ALARM_EN
  logic [4:0] r_alarm_h;
  logic [5:0] r_alarm_m;
  logic       r_alarm_hit;
  logic       w_alarm_match;

  assign w_alarm_match = (w_next.h == r_alarm_h) && (w_next.m == r_alarm_m) &&
                         (w_next.s == 6'd0);

  // Alarm setpoint capture and hit detection on tick-driven arrival only.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_alarm_h   <= '0;
      r_alarm_m   <= '0;
      r_alarm_hit <= 1'b0;
    end else begin
      if (i_alarm_wr && (i_alarm_h <= 5'(HR_MAX)) && (i_alarm_m <= 6'(MIN_MAX))) begin
        r_alarm_h <= i_alarm_h;
        r_alarm_m <= i_alarm_m;
      end
      r_alarm_hit <= w_tick_apply & i_alarm_arm & w_alarm_match;
    end
  end

  assign o_alarm_hit = r_alarm_hit;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{i_alarm_wr, i_alarm_h, i_alarm_m, i_alarm_arm, w_tick_apply};
  assign o_alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_dig_clock_core.sv
// Directed bench for dig_clock_core with TICK_DIV=4.
module tb_dig_clock_core;

  logic       clk = 1'b0;
  logic       reset, run, mode, load_valid, pm_in;
  logic [5:0] s_in, m_in;
  logic [4:0] h_in;
  logic       alarm_wr, alarm_arm;
  logic [4:0] alarm_h;
  logic [5:0] alarm_m;
  logic       load_ready, load_err, pm, sec_tick, day_wrap, alarm_hit;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dig_clock_core #(.TICK_DIV(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_mode(mode),
    .i_load_valid(load_valid), .o_load_ready(load_ready),
    .i_s_in(s_in), .i_m_in(m_in), .i_h_in(h_in), .i_pm_in(pm_in),
    .o_load_err(load_err), .o_seconds(seconds), .o_minutes(minutes),
    .o_hours(hours), .o_pm(pm), .o_sec_tick(sec_tick), .o_day_wrap(day_wrap),
    .i_alarm_wr(alarm_wr), .i_alarm_h(alarm_h), .i_alarm_m(alarm_m),
    .i_alarm_arm(alarm_arm), .o_alarm_hit(alarm_hit)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m,
                         input logic [5:0] s, input logic p);
    h_in = h; m_in = m; s_in = s; pm_in = p;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; mode = 1'b0; load_valid = 1'b0;
    s_in = '0; m_in = '0; h_in = '0; pm_in = 1'b0;
    alarm_wr = 1'b0; alarm_h = '0; alarm_m = '0; alarm_arm = 1'b0;
    step(); step();
    n_cmp++;
    if ({hours, minutes, seconds, pm} !== 18'd0) begin
      n_err++; $display("FAIL reset_time got %0d:%0d:%0d pm=%0b want 0:0:0 pm=0", hours, minutes, seconds, pm);
    end
    n_cmp++;
    if ({load_ready, load_err, sec_tick, day_wrap, alarm_hit} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %05b want 00000", {load_ready, load_err, sec_tick, day_wrap, alarm_hit});
    end
    mode = 1'b1; #1;
    n_cmp++;
    if (hours !== 5'd12 || pm !== 1'b0) begin
      n_err++; $display("FAIL reset_12h got h=%0d pm=%0b want h=12 pm=0", hours, pm);
    end
    mode = 1'b0;
  endtask

  task automatic test_count();
    reset = 1'b1; run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (sec_tick !== ((k % 4) == 0)) begin
        n_err++; $display("FAIL count_tick cycle %0d got %0b want %0b", k, sec_tick, (k % 4) == 0);
      end
    end
    n_cmp++;
    if (seconds !== 6'd3 || load_ready !== 1'b1) begin
      n_err++; $display("FAIL count_sec got s=%0d rdy=%0b want s=3 rdy=1", seconds, load_ready);
    end
  endtask

  task automatic test_rollover();
    int wraps;
    wraps = 0;
    do_load(5'd23, 6'd59, 6'd58, 1'b0);
    n_cmp++;
    if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd58}) begin
      n_err++; $display("FAIL roll_load got %0d:%0d:%0d want 23:59:58", hours, minutes, seconds);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (day_wrap === 1'b1) wraps++;
      if (k == 4) begin
        n_cmp++;
        if (seconds !== 6'd59 || day_wrap !== 1'b0) begin
          n_err++; $display("FAIL roll_first got s=%0d wrap=%0b want s=59 wrap=0", seconds, day_wrap);
        end
      end
      if (k == 8) begin
        n_cmp++;
        if ({hours, minutes, seconds} !== 17'd0 || day_wrap !== 1'b1) begin
          n_err++; $display("FAIL roll_wrap got %0d:%0d:%0d wrap=%0b want 0:0:0 wrap=1", hours, minutes, seconds, day_wrap);
        end
      end
    end
    n_cmp++;
    if (wraps != 1) begin
      n_err++; $display("FAIL roll_count got %0d want 1", wraps);
    end
  endtask

  task automatic test_12h();
    run = 1'b0; mode = 1'b1;
    do_load(5'd12, 6'd0, 6'd0, 1'b0);
    n_cmp++;
    if (hours !== 5'd12 || pm !== 1'b0) begin
      n_err++; $display("FAIL h12_midnight got h=%0d pm=%0b want h=12 pm=0", hours, pm);
    end
    mode = 1'b0; #1;
    n_cmp++;
    if (hours !== 5'd0 || pm !== 1'b0) begin
      n_err++; $display("FAIL h24_midnight got h=%0d pm=%0b want h=0 pm=0", hours, pm);
    end
    mode = 1'b1;
    do_load(5'd3, 6'd45, 6'd6, 1'b1);
    n_cmp++;
    if (hours !== 5'd3 || pm !== 1'b1 || minutes !== 6'd45) begin
      n_err++; $display("FAIL h12_pm got h=%0d pm=%0b m=%0d want h=3 pm=1 m=45", hours, pm, minutes);
    end
    mode = 1'b0; #1;
    n_cmp++;
    if (hours !== 5'd15 || pm !== 1'b0) begin
      n_err++; $display("FAIL h24_pm got h=%0d pm=%0b want h=15 pm=0", hours, pm);
    end
  endtask

  task automatic test_load_err();
    do_load(5'd0, 6'd0, 6'd60, 1'b0);
    n_cmp++;
    if (load_err !== 1'b1 || {hours, minutes, seconds} !== {5'd15, 6'd45, 6'd6}) begin
      n_err++; $display("FAIL err_sec got err=%0b %0d:%0d:%0d want err=1 15:45:6", load_err, hours, minutes, seconds);
    end
    step();
    n_cmp++;
    if (load_err !== 1'b0) begin
      n_err++; $display("FAIL err_pulse got %0b want 0", load_err);
    end
    mode = 1'b1;
    do_load(5'd0, 6'd0, 6'd0, 1'b0);
    n_cmp++;
    if (load_err !== 1'b1 || hours !== 5'd3 || pm !== 1'b1 || seconds !== 6'd6) begin
      n_err++; $display("FAIL err_h0 got err=%0b h=%0d pm=%0b s=%0d want err=1 h=3 pm=1 s=6", load_err, hours, pm, seconds);
    end
    mode = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (seconds !== 6'd6 || load_err !== 1'b0) begin
      n_err++; $display("FAIL frozen got s=%0d err=%0b want s=6 err=0", seconds, load_err);
    end
  endtask

  task automatic test_load_tick();
    run = 1'b1;
    do_load(5'd1, 6'd2, 6'd3, 1'b0);
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (sec_tick !== 1'b0 || seconds !== 6'd3) begin
      n_err++; $display("FAIL lt_pre got tick=%0b s=%0d want tick=0 s=3", sec_tick, seconds);
    end
    do_load(5'd10, 6'd0, 6'd0, 1'b0);
    n_cmp++;
    if ({hours, minutes, seconds} !== {5'd10, 12'd0} || sec_tick !== 1'b0) begin
      n_err++; $display("FAIL lt_load got %0d:%0d:%0d tick=%0b want 10:0:0 tick=0", hours, minutes, seconds, sec_tick);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if (sec_tick !== (k == 4) || seconds !== ((k == 4) ? 6'd1 : 6'd0)) begin
        n_err++; $display("FAIL lt_after cycle %0d got tick=%0b s=%0d want tick=%0b", k, sec_tick, seconds, k == 4);
      end
    end
  endtask

  task automatic test_alarm();
    int hits;
    run = 1'b1; mode = 1'b0;
`ifdef DIG_CLOCK_ALARM_EN
    alarm_wr = 1'b1; alarm_h = 5'd7; alarm_m = 6'd30; step();
    alarm_h = 5'd24; alarm_m = 6'd0; step();
    alarm_wr = 1'b0; alarm_arm = 1'b1;
    do_load(5'd7, 6'd29, 6'd59, 1'b0);
    hits = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (alarm_hit === 1'b1) hits++;
      if (k == 4) begin
        n_cmp++;
        if (alarm_hit !== 1'b1 || minutes !== 6'd30) begin
          n_err++; $display("FAIL alarm_hit got hit=%0b m=%0d want hit=1 m=30", alarm_hit, minutes);
        end
      end
    end
    n_cmp++;
    if (hits != 1) begin
      n_err++; $display("FAIL alarm_count got %0d want 1", hits);
    end
    alarm_arm = 1'b0;
    do_load(5'd7, 6'd29, 6'd59, 1'b0);
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (alarm_hit === 1'b1) hits++;
    end
    n_cmp++;
    if (hits != 0) begin
      n_err++; $display("FAIL alarm_disarmed got %0d want 0", hits);
    end
    alarm_arm = 1'b1;
    do_load(5'd7, 6'd30, 6'd0, 1'b0);
    hits = (alarm_hit === 1'b1) ? 1 : 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (alarm_hit === 1'b1) hits++;
    end
    n_cmp++;
    if (hits != 0) begin
      n_err++; $display("FAIL alarm_on_load got %0d want 0", hits);
    end
`else
    alarm_wr = 1'b1; alarm_h = 5'd7; alarm_m = 6'd30; step();
    alarm_wr = 1'b0; alarm_arm = 1'b1;
    do_load(5'd7, 6'd29, 6'd59, 1'b0);
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (alarm_hit !== 1'b0) hits++;
    end
    n_cmp++;
    if (hits != 0) begin
      n_err++; $display("FAIL alarm_tied got %0d nonzero cycles want 0", hits);
    end
`endif
    alarm_arm = 1'b0;
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    do_load(5'd5, 6'd5, 6'd5, 1'b0);
    h_in = 5'd9; m_in = 6'd9; s_in = 6'd9; load_valid = 1'b1; reset = 1'b0;
    step();
    load_valid = 1'b0;
    n_cmp++;
    if ({hours, minutes, seconds} !== 17'd0 || load_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_mid got %0d:%0d:%0d rdy=%0b want 0:0:0 rdy=0", hours, minutes, seconds, load_ready);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_12h();
    test_load_err();
    test_load_tick();
    test_alarm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
